// File: rtl/param_wave_generator.sv
// Multi-mode waveform generator: triangle, saw-up, saw-down or square samples
// within a [lo, hi] window; a shadowed config is applied only at period boundaries.
module param_wave_generator #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEF_MODE = 0,
  parameter int unsigned DEF_STEP = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             cfg_load,
  input  logic [1:0]       cfg_mode,
  input  logic [WIDTH-1:0] cfg_step,
  input  logic [WIDTH-1:0] cfg_lo,
  input  logic [WIDTH-1:0] cfg_hi,
  output logic [WIDTH-1:0] wave_out,
  output logic             period_start,
  output logic             cfg_pending,
  output logic             cfg_err
);

  localparam int unsigned EW = WIDTH + 1;
  localparam logic [1:0]  DEF_MODE_L = 2'(DEF_MODE);

  typedef enum logic [1:0] {
    MODE_TRI    = 2'd0,
    MODE_SAW_UP = 2'd1,
    MODE_SAW_DN = 2'd2,
    MODE_SQUARE = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_e;

  typedef struct packed {
    mode_e            mode;
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
  } cfg_t;

  localparam cfg_t DEF_CFG = '{
    mode: mode_e'(DEF_MODE_L),
    step: WIDTH'(DEF_STEP),
    lo:   '0,
    hi:   '1
  };

  cfg_t             act_q, act_d;
  cfg_t             shd_q, shd_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  dir_e             dir_q, dir_d;
  logic             pend_q, pend_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] wave_q, wave_d;
  logic             pstart_q, pstart_d;

  logic [WIDTH-1:0] step_eff;
  logic [EW-1:0]    cnt_x, step_x, lo_x, hi_x, up_sum, lo_sum;
  logic [WIDTH-1:0] out_val;
  logic             at_start;
  logic             wrap;
  logic             apply;

  // Bound compares run one bit wider so cnt+step can never wrap past hi.
  assign step_eff = (act_q.step == '0) ? WIDTH'(1) : act_q.step;
  assign cnt_x    = {1'b0, cnt_q};
  assign step_x   = {1'b0, step_eff};
  assign lo_x     = {1'b0, act_q.lo};
  assign hi_x     = {1'b0, act_q.hi};
  assign up_sum   = cnt_x + step_x;
  assign lo_sum   = lo_x + step_x;

  assign out_val  = (act_q.mode == MODE_SQUARE) ?
                    ((dir_q == DIR_UP) ? act_q.hi : act_q.lo) : cnt_q;
  assign at_start = (act_q.mode == MODE_SAW_DN) ? (cnt_q == act_q.hi) :
                    ((cnt_q == act_q.lo) &&
                     ((act_q.mode == MODE_SAW_UP) || (dir_q == DIR_UP)));

  // Next-state: sequencer step, config apply, shadow capture.
  always_comb begin
    act_d    = act_q;
    shd_d    = shd_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    pend_d   = pend_q;
    err_d    = err_q;
    wave_d   = wave_q;
    pstart_d = 1'b0;
    wrap     = 1'b0;

    if (err_q) begin
      cnt_d  = act_q.lo;
      wave_d = act_q.lo;
    end else if (en) begin
      wave_d   = out_val;
      pstart_d = at_start;
      case (act_q.mode)
        MODE_SAW_UP: begin
          if (up_sum > hi_x) begin
            cnt_d = act_q.lo;
            wrap  = 1'b1;
          end else begin
            cnt_d = up_sum[WIDTH-1:0];
          end
        end
        MODE_SAW_DN: begin
          if (cnt_x < lo_sum) begin
            cnt_d = act_q.hi;
            wrap  = 1'b1;
          end else begin
            cnt_d = cnt_q - step_eff;
          end
        end
        MODE_TRI, MODE_SQUARE: begin
          if (dir_q == DIR_UP) begin
            if (up_sum >= hi_x) begin
              cnt_d = act_q.hi;
              dir_d = DIR_DN;
            end else begin
              cnt_d = up_sum[WIDTH-1:0];
            end
          end else begin
            if (cnt_x <= lo_sum) begin
              cnt_d = act_q.lo;
              dir_d = DIR_UP;
              wrap  = 1'b1;
            end else begin
              cnt_d = cnt_q - step_eff;
            end
          end
        end
      endcase
    end

    // An invalid active config never wraps, so a pending one is taken at once.
    apply = pend_q && (!en || wrap || err_q);
    if (apply) begin
      act_d  = shd_q;
      err_d  = (shd_q.lo >= shd_q.hi);
      cnt_d  = ((shd_q.mode == MODE_SAW_DN) && !err_d) ? shd_q.hi : shd_q.lo;
      dir_d  = DIR_UP;
      pend_d = 1'b0;
    end

    if (cfg_load) begin
      shd_d  = '{mode: mode_e'(cfg_mode), step: cfg_step, lo: cfg_lo, hi: cfg_hi};
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      act_q    <= DEF_CFG;
      shd_q    <= DEF_CFG;
      cnt_q    <= '0;
      dir_q    <= DIR_UP;
      pend_q   <= 1'b0;
      err_q    <= 1'b0;
      wave_q   <= '0;
      pstart_q <= 1'b0;
    end else begin
      act_q    <= act_d;
      shd_q    <= shd_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      pend_q   <= pend_d;
      err_q    <= err_d;
      wave_q   <= wave_d;
      pstart_q <= pstart_d;
    end
  end

  assign wave_out     = wave_q;
  assign period_start = pstart_q;
  assign cfg_pending  = pend_q;
  assign cfg_err      = err_q;

endmodule
